// File: rtl/bitserial_mac_seq.sv
// Self-sequencing bit-serial MAC lane: accepts a full vector, walks the non-zero weight-magnitude
// columns MSB first through an adder tree, and returns one saturated (optionally pooled) result.
module bitserial_mac_seq #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned VEC_LENGTH   = 16,
  parameter int unsigned MAG_BITS     = 7,
  parameter int unsigned RESULT_WIDTH = 2 * DATA_WIDTH,
  parameter int unsigned ACC_WIDTH    = DATA_WIDTH + MAG_BITS + $clog2(VEC_LENGTH) + 1
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic signed [DATA_WIDTH-1:0]       act_in [VEC_LENGTH],
  input  logic                               w_sign [VEC_LENGTH],
  input  logic        [MAG_BITS-1:0]         w_mag  [VEC_LENGTH],
  input  logic                               load_accum,
  input  logic                               is_pooling,
  input  logic signed [RESULT_WIDTH-1:0]     result_prev,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic signed [RESULT_WIDTH-1:0]     result,
  output logic        [$clog2(MAG_BITS+1)-1:0] busy_cycles
);

  localparam int unsigned TermWidth = DATA_WIDTH + 1;
  localparam int unsigned PsumWidth = DATA_WIDTH + 1 + $clog2(VEC_LENGTH);
  localparam int unsigned ColWidth  = (MAG_BITS > 1) ? $clog2(MAG_BITS) : 1;
  localparam int unsigned CntWidth  = $clog2(MAG_BITS + 1);

  localparam logic signed [ACC_WIDTH-1:0] SatMax =
    {{(ACC_WIDTH - RESULT_WIDTH + 1){1'b0}}, {(RESULT_WIDTH - 1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SatMin =
    {{(ACC_WIDTH - RESULT_WIDTH + 1){1'b1}}, {(RESULT_WIDTH - 1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StCompute, StDone} state_e;

  state_e                           state_q;
  logic signed [DATA_WIDTH-1:0]     act_q  [VEC_LENGTH];
  logic                             sign_q [VEC_LENGTH];
  logic        [MAG_BITS-1:0]       mag_q  [VEC_LENGTH];
  logic                             pool_q;
  logic signed [RESULT_WIDTH-1:0]   prev_q;
  logic        [MAG_BITS-1:0]       mask_q;
  logic signed [ACC_WIDTH-1:0]      acc_q;
  logic        [CntWidth-1:0]       cnt_q;

  logic        [MAG_BITS-1:0]       in_mask;
  logic        [ColWidth-1:0]       col;
  logic signed [TermWidth-1:0]      act_ext [VEC_LENGTH];
  logic signed [TermWidth-1:0]      term    [VEC_LENGTH];
  logic signed [PsumWidth-1:0]      tree    [2*VEC_LENGTH];
  logic signed [PsumWidth-1:0]      psum;
  logic signed [ACC_WIDTH-1:0]      shifted;
  logic signed [ACC_WIDTH-1:0]      acc_nxt;
  logic        [MAG_BITS-1:0]       mask_rem;
  logic signed [RESULT_WIDTH-1:0]   sat;
  logic signed [RESULT_WIDTH-1:0]   pooled;

  assign in_ready = (state_q == StIdle);

  always_comb begin
    in_mask = '0;
    for (int l = 0; l < VEC_LENGTH; l++) begin
      in_mask = in_mask | w_mag[l];
    end
  end

  // Last match wins, so col ends up as the highest remaining column.
  always_comb begin
    col = '0;
    for (int b = 0; b < MAG_BITS; b++) begin
      if (mask_q[b]) col = ColWidth'(b);
    end
  end

  // Heap-ordered adder tree: leaves at [VEC_LENGTH..2*VEC_LENGTH-1], root at [1].
  always_comb begin
    for (int i = 0; i < 2 * VEC_LENGTH; i++) begin
      tree[i] = '0;
    end
    for (int l = 0; l < VEC_LENGTH; l++) begin
      act_ext[l] = TermWidth'(act_q[l]);
      if (mag_q[l][col]) begin
        term[l] = sign_q[l] ? -act_ext[l] : act_ext[l];
      end else begin
        term[l] = '0;
      end
      tree[VEC_LENGTH+l] = PsumWidth'(term[l]);
    end
    for (int i = VEC_LENGTH - 1; i >= 1; i--) begin
      tree[i] = tree[2*i] + tree[2*i+1];
    end
    psum = tree[1];
  end

  always_comb begin
    shifted  = ACC_WIDTH'(psum) <<< col;
    acc_nxt  = acc_q + shifted;
    mask_rem = mask_q & ~(MAG_BITS'(1) << col);
    if (acc_nxt > SatMax) begin
      sat = SatMax[RESULT_WIDTH-1:0];
    end else if (acc_nxt < SatMin) begin
      sat = SatMin[RESULT_WIDTH-1:0];
    end else begin
      sat = acc_nxt[RESULT_WIDTH-1:0];
    end
    pooled = (pool_q && (prev_q > sat)) ? prev_q : sat;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      out_valid   <= 1'b0;
      result      <= '0;
      busy_cycles <= '0;
      acc_q       <= '0;
      mask_q      <= '0;
      cnt_q       <= '0;
      pool_q      <= 1'b0;
      prev_q      <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            act_q   <= act_in;
            sign_q  <= w_sign;
            mag_q   <= w_mag;
            pool_q  <= is_pooling;
            prev_q  <= result_prev;
            acc_q   <= load_accum ? ACC_WIDTH'(result_prev) : '0;
            mask_q  <= in_mask;
            cnt_q   <= '0;
            state_q <= StCompute;
          end
        end
        StCompute: begin
          // An empty mask still spends this one cycle adding a zero psum.
          acc_q  <= acc_nxt;
          mask_q <= mask_rem;
          cnt_q  <= cnt_q + CntWidth'(1);
          if (mask_rem == '0) begin
            state_q     <= StDone;
            out_valid   <= 1'b1;
            result      <= pooled;
            busy_cycles <= cnt_q + CntWidth'(1);
          end
        end
        StDone: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_bitserial_mac_seq.sv
// Directed bench for bitserial_mac_seq: hand-computed dot products, latency, handshake and reset.
module tb_bitserial_mac_seq;

  localparam int DW = 8;
  localparam int VL = 16;
  localparam int MB = 7;
  localparam int RW = 16;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 in_valid;
  logic                 in_ready;
  logic signed [DW-1:0] act [VL];
  logic                 sgn [VL];
  logic [MB-1:0]        mag [VL];
  logic                 load_accum;
  logic                 is_pooling;
  logic signed [RW-1:0] result_prev;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [RW-1:0] result;
  logic [2:0]           busy_cycles;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  bitserial_mac_seq dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .act_in      (act),
    .w_sign      (sgn),
    .w_mag       (mag),
    .load_accum  (load_accum),
    .is_pooling  (is_pooling),
    .result_prev (result_prev),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .busy_cycles (busy_cycles)
  );

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic set_all(input int a, input bit s, input int m);
    for (int i = 0; i < VL; i++) begin
      act[i] = DW'(a);
      sgn[i] = s;
      mag[i] = MB'(m);
    end
  endtask

  task automatic start_job(input string tag);
    @(negedge clk);
    in_valid = 1'b1;
    for (int i = 0; i < 20 && !in_ready; i++) @(negedge clk);
    check({tag, ":in_ready"}, in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    // Operands must have been captured on accept.
    set_all(85, 1'b1, 127);
  endtask

  task automatic wait_done(input string tag, input int n);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!out_valid && k < 20);
    check({tag, ":latency"}, k, n + 1);
  endtask

  task automatic release_out(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    check({tag, ":valid_drop"}, out_valid, 0);
    check({tag, ":ready_back"}, in_ready, 1);
  endtask

  task automatic run_job(input string tag, input longint exp_res, input int exp_n);
    start_job(tag);
    wait_done(tag, exp_n);
    check({tag, ":result"}, result, exp_res);
    check({tag, ":busy"}, busy_cycles, exp_n);
    release_out(tag);
    load_accum  = 1'b0;
    is_pooling  = 1'b0;
    result_prev = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    reset       = 1'b1;
    in_valid    = 1'b0;
    out_ready   = 1'b0;
    load_accum  = 1'b0;
    is_pooling  = 1'b0;
    result_prev = '0;
    set_all(0, 1'b0, 0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst:in_ready", in_ready, 1);
    check("rst:out_valid", out_valid, 0);
    check("rst:result", result, 0);
    check("rst:busy", busy_cycles, 0);

    set_all(1, 1'b0, 1);
    run_job("ones", 16, 1);

    set_all(127, 1'b0, 127);
    run_job("sat_pos", 32767, 7);

    set_all(-128, 1'b1, 127);
    run_job("neg_neg", 32767, 7);

    set_all(-128, 1'b0, 127);
    run_job("neg_pos", -32768, 7);

    set_all(5, 1'b0, 0);
    run_job("zero_mask", 0, 1);

    set_all(10, 1'b0, 0);
    for (int i = 0; i < 4; i++) mag[i] = 7'b1000001;
    run_job("skip", 2600, 2);

    set_all(2, 1'b0, 3);
    load_accum  = 1'b1;
    result_prev = -16'sd100;
    run_job("seed", -4, 2);

    set_all(0, 1'b0, 0);
    act[0] = -8'sd5;
    mag[0] = 7'd1;
    is_pooling  = 1'b1;
    result_prev = 16'sd100;
    run_job("pool_prev", 100, 1);

    set_all(0, 1'b0, 0);
    act[0] = -8'sd5;
    mag[0] = 7'd1;
    is_pooling  = 1'b1;
    result_prev = -16'sd100;
    run_job("pool_acc", -5, 1);

    set_all(0, 1'b0, 0);
    act[0] = 8'sd50;
    mag[0] = 7'd1;
    load_accum  = 1'b1;
    is_pooling  = 1'b1;
    result_prev = -16'sd100;
    run_job("seed_pool", -50, 1);

    // Mixed signs: sum of (+/-)(i-8)*i = 112 - 168 = -56, columns 0..3.
    for (int i = 0; i < VL; i++) begin
      act[i] = DW'(i - 8);
      sgn[i] = i[0];
      mag[i] = MB'(i);
    end
    start_job("hold");
    wait_done("hold", 4);
    in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("hold:result", result, -56);
      check("hold:out_valid", out_valid, 1);
      check("hold:in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    check("hold:busy", busy_cycles, 4);
    release_out("hold");

    set_all(127, 1'b0, 127);
    start_job("rst_mid");
    @(negedge clk);
    @(negedge clk);
    check("rst_mid:busy_state", in_ready, 0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_mid:in_ready", in_ready, 1);
    check("rst_mid:out_valid", out_valid, 0);
    check("rst_mid:result", result, 0);
    check("rst_mid:busy", busy_cycles, 0);
    repeat (10) @(negedge clk);
    check("rst_mid:no_ghost", out_valid, 0);

    set_all(1, 1'b0, 1);
    run_job("after_rst", 16, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bitserial_mac_seq.md
Name: bitserial_mac_seq

Overview:
- Next-generation bit-serial MAC lane with a self-sequencing FSM.
- Accepts a full vector of signed activations and sign-magnitude weights through a valid/ready handshake, then walks the weight-magnitude bit columns MSB to LSB, skipping all-zero columns.
- Each processed column is reduced by a parametrised adder tree, shifted and accumulated.
- Returns one saturated dot-product (optionally max-pooled against a previous result) through an output handshake.
- Sits in the PE array where the fixed 16-lane, externally sequenced MAC sat.

Parameters:
- DATA_WIDTH, 8, activation width (signed two's complement).
- VEC_LENGTH, 16, lane count; power of 2, >=2.
- MAG_BITS, 7, weight magnitude width (weight = sign + MAG_BITS).
- RESULT_WIDTH, 2*DATA_WIDTH, output width (signed).
- ACC_WIDTH, DATA_WIDTH+MAG_BITS+$clog2(VEC_LENGTH)+1, accumulator width; must be >= RESULT_WIDTH.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous active-high reset.
- in_valid  input  1  input vector valid.
- in_ready  output  1  block can accept a vector.
- act_in  input  [DATA_WIDTH-1:0] x VEC_LENGTH (unpacked array)  signed activations.
- w_sign  input  1 x VEC_LENGTH  weight sign per lane (1 = negative).
- w_mag  input  [MAG_BITS-1:0] x VEC_LENGTH  weight magnitude per lane.
- load_accum  input  1  seed the accumulator with result_prev (sampled on accept).
- is_pooling  input  1  output max(acc, result_prev) (sampled on accept).
- result_prev  input  RESULT_WIDTH  signed seed / pooling operand (sampled on accept).
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- result  output  RESULT_WIDTH  signed result.
- busy_cycles  output  $clog2(MAG_BITS+1)  compute cycles used by the last job (debug).

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-high, on port reset. It forces state IDLE, out_valid=0, result=0, busy_cycles=0, accumulator=0, and drops any job in flight (reset mid-COMPUTE or mid-DONE discards it).
- FSM states are IDLE, COMPUTE and DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: register act_in, w_sign, w_mag, load_accum, is_pooling, result_prev.
  - Set acc = load_accum ? sign-extended result_prev : 0.
  - Compute the column mask colmask[b] = OR over lanes of w_mag[lane][b].
  - Go to COMPUTE.
  - in_ready is 0 in COMPUTE and DONE.
- COMPUTE, one cycle per nonzero column:
  - b = highest set bit of the remaining mask, found by a priority encoder.
  - Lane term = w_mag[lane][b] ? (w_sign ? -act : act) : 0, held at DATA_WIDTH+1 bits so that -(-128) = +128 is exact.
  - The adder tree grows one bit per level. psum width = DATA_WIDTH+1+$clog2(VEC_LENGTH).
  - acc <= acc + (psum <<< b), sign-extended to ACC_WIDTH. Then clear mask bit b.
  - When the remaining mask after this cycle is 0, go to DONE.
  - An all-zero mask on entry still costs exactly 1 COMPUTE cycle, adds 0, then goes to DONE.
- Latency: accept at cycle T. COMPUTE spans T+1..T+N with N = max(1, popcount(colmask)). out_valid rises at T+N+1.
- DONE:
  - out_valid=1.
  - sat = acc clamped to [-2^(RESULT_WIDTH-1), 2^(RESULT_WIDTH-1)-1].
  - result = is_pooling ? max(sat, result_prev) : sat, with a signed compare.
  - result and out_valid stay stable until out_ready. On out_valid&&out_ready go to IDLE next cycle; in_ready rises the following cycle, with no same-cycle bypass.
  - busy_cycles = N, updated on entering DONE.
- Outside DONE, result holds its last value and out_valid=0.
- Inputs are ignored whenever in_ready=0. out_ready is ignored when out_valid=0.
- load_accum and is_pooling set together: seed with result_prev, then pool against the same result_prev.

Test Plan:
- Single lane: all act=1, all w_mag=1, sign=0, default params -> N=1, out_valid at T+2, result=16, busy_cycles=1.
- Saturation: all act=127, w_mag=127, sign=0 (acc = 16*127*127 = 258064) -> N=7, result=32767.
- Negative edge: all act=-128, w_mag=127, sign=1 -> acc=+260096, result=32767. Same inputs with sign=0 -> acc=-260096, result=-32768.
- Zero skip: all w_mag=0 -> N=1, result=0. Only lanes 0..3 w_mag=7'b1000001, act=10 -> N=2, result=4*10*65=2600.
- Seed and pool:
  - load_accum=1, result_prev=-100, all act=2, w_mag=3 -> result=-100+96=-4.
  - is_pooling=1, result_prev=100, act chosen so acc=-5 -> result=100.
- Handshake and reset:
  - Hold out_ready=0 for 5 cycles -> result and out_valid stable, in_ready=0 throughout.
  - Assert reset during COMPUTE -> next cycle IDLE, out_valid=0, result=0. A new job then runs correctly.
